time_display: RTL

Four-digit multiplexed seven-segment driver for the BASYS3 display. It consumes the 16-bit BCD `time_reading` and the `complete` flag produced by the countdown `Counter` and renders MM.SS on the board's common-anode display. The block is the read side of the `Counter` time interface and sits between `Counter` and the top-level FPGA pins.

---
 rtl/time_display.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/time_display.sv
`default_nettype none
// ============================================================================
// Module   : time_display
// Brief    : Four-digit multiplexed common-anode seven-segment driver (MM.SS)
//            with tear-free frame snapshots and leading-zero blanking.
//            Optional completion blink enabled by BLINK_ON_COMPLETE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module time_display #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int DIGIT_PERIOD = 100_000
) (
    input  logic        clk,
    input  logic        init_regs,
    input  logic [15:0] time_reading,
    input  logic        complete,
    output logic [3:0]  anodes,
    output logic [6:0]  segments,
    output logic        dp
);

    localparam int                    c_refresh_w   = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam logic [c_refresh_w-1:0] c_refresh_max = c_refresh_w'(DIGIT_PERIOD - 1);
    localparam logic [6:0]            c_seg_blank   = 7'b1111111;
    localparam logic [6:0]            c_seg_dash    = 7'b0111111;

    logic [c_refresh_w-1:0] r_refresh_cnt;
    logic [1:0]             r_digit_idx;
    logic [15:0]            r_snapshot;
    logic                   r_complete_d;
    logic                   w_refresh_wrap;
    logic [3:0]             w_nibble;
    logic [3:0]             w_anodes;
    logic [6:0]             w_segments;
    logic                   w_blank;

    assign w_refresh_wrap = (r_refresh_cnt == c_refresh_max);

    // Snapshot only at the frame boundary so one frame never mixes two samples.
    always_ff @(posedge clk) begin
        if (init_regs) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= 2'd0;
            r_snapshot    <= 16'h0000;
        end else if (w_refresh_wrap) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= r_digit_idx + 2'd1;
            if (r_digit_idx == 2'd3) begin
                r_snapshot <= time_reading;
            end
        end else begin
            r_refresh_cnt <= r_refresh_cnt + c_refresh_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        r_complete_d <= complete;
    end

    always_comb begin
        w_nibble = r_snapshot[3:0];
        w_anodes = 4'b1110;
        case (r_digit_idx)
            2'd0: begin w_nibble = r_snapshot[3:0];   w_anodes = 4'b1110; end
            2'd1: begin w_nibble = r_snapshot[7:4];   w_anodes = 4'b1101; end
            2'd2: begin w_nibble = r_snapshot[11:8];  w_anodes = 4'b1011; end
            default: begin w_nibble = r_snapshot[15:12]; w_anodes = 4'b0111; end
        endcase
    end

    always_comb begin
        w_segments = c_seg_dash;
        case (w_nibble)
            4'd0: w_segments = 7'b1000000;
            4'd1: w_segments = 7'b1111001;
            4'd2: w_segments = 7'b0100100;
            4'd3: w_segments = 7'b0110000;
            4'd4: w_segments = 7'b0011001;
            4'd5: w_segments = 7'b0010010;
            4'd6: w_segments = 7'b0000010;
            4'd7: w_segments = 7'b1111000;
            4'd8: w_segments = 7'b0000000;
            4'd9: w_segments = 7'b0010000;
            default: w_segments = c_seg_dash;
        endcase
        // Tens-of-minutes zero is dark but its anode keeps the scan cadence.
        if ((r_digit_idx == 2'd3) && (w_nibble == 4'd0)) begin
            w_segments = c_seg_blank;
        end
    end

`ifdef BLINK_ON_COMPLETE_EN
    localparam int                  c_phase_w    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [c_phase_w-1:0] c_phase_max  = c_phase_w'(CLK_FREQ - 1);
    localparam logic [c_phase_w-1:0] c_phase_half = c_phase_w'(CLK_FREQ / 2);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BLINK = 1'b1
    } blink_state_t;

    blink_state_t         r_state;
    blink_state_t         w_state_next;
    logic [c_phase_w-1:0] r_blink_cnt;
    logic [1:0]           r_blink_sec;
    logic                 w_complete_rise;
    logic                 w_blink_last;

    assign w_complete_rise = complete & ~r_complete_d;
    assign w_blink_last    = (r_blink_cnt == c_phase_max) && (r_blink_sec == 2'd2);

    always_ff @(posedge clk) begin
        if (init_regs) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_complete_rise) w_state_next = ST_BLINK;
            ST_BLINK: if (!w_complete_rise && w_blink_last) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Phase counter within the current second plus a second counter (0..2).
    always_ff @(posedge clk) begin
        if (init_regs || w_complete_rise) begin
            r_blink_cnt <= '0;
            r_blink_sec <= 2'd0;
        end else if (r_state == ST_BLINK) begin
            if (r_blink_cnt == c_phase_max) begin
                r_blink_cnt <= '0;
                r_blink_sec <= r_blink_sec + 2'd1;
            end else begin
                r_blink_cnt <= r_blink_cnt + c_phase_w'(1);
            end
        end
    end

    assign w_blank = (r_state == ST_BLINK) && (r_blink_cnt < c_phase_half);
`else
    logic w_unused_complete;
    assign w_unused_complete = complete ^ r_complete_d ^ (CLK_FREQ > 0);
    assign w_blank           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (init_regs || w_blank) begin
            anodes   <= 4'b1111;
            segments <= c_seg_blank;
            dp       <= 1'b1;
        end else begin
            anodes   <= w_anodes;
            segments <= w_segments;
            dp       <= (r_digit_idx != 2'd2);
        end
    end

endmodule
`default_nettype wire
